// File: rtl/io_dma_pkg.sv
// io_dma_pkg: shared FSM state encoding and bus width for the DMA peripheral
package io_dma_pkg;
  localparam int BUS_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_RD, ST_WR, ST_HOLD} dma_state_e;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: receive FIFO, power-of-two DEPTH, pointers wrap naturally
//   i_push/i_data  write side (dropped when full unless popped same edge)
//   i_pop          read side (ignored when empty), o_head is the oldest entry
//   o_full/o_empty/o_count  occupancy status
module io_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr, w_rd;
  assign o_full  = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_rd    = i_pop && !o_empty;
  // a pop frees the slot this edge, so a push at full is still accepted
  assign w_wr    = i_push && (!o_full || w_rd);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
endmodule

// File: rtl/io_dma_periph.sv
// io_dma_periph: DMA-serviced I/O peripheral with receive FIFO and transmit latch
//   clk, Reset (async, active-low)
//   key_valid/key_data        device-side bytes pushed into the FIFO
//   DREQ/DACK/IOR/IOW/EOP     DMA handshake; IReady/TReady per-beat flow control
//   Data_Bus                  shared bus, driven only while reading in RD
//   IOflag                    FIFO non-empty (pending device-to-memory transfer)
//   tx_data/tx_valid/tx_ack   last DMA-written byte and its consumer handshake
//   overflow                  sticky: a push was dropped at full
module io_dma_periph
  import io_dma_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] key_data,
  output logic             DREQ,
  input  logic             DACK,
  input  logic             IOR,
  input  logic             IOW,
  input  logic             EOP,
  input  logic             IReady,
  output wire              TReady,
  inout  wire  [WIDTH-1:0] Data_Bus,
  output logic             IOflag,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ack,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  dma_state_e       r_state;
  logic             r_dreq, r_ioflag, r_tx_valid, r_ovf;
  logic [WIDTH-1:0] r_tx_data, w_head;
  logic             w_full, w_empty, w_pop, w_push_ok, w_cap, w_tready;
  logic             w_go, w_rd_go, w_wr_go;
  logic [AW:0]      w_count, w_cnt_nxt;
  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (Reset),
    .i_push  (key_valid),
    .i_data  (key_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // EOP ends the burst without consuming the beat presented on that edge
  assign w_pop     = r_state == ST_RD && DACK && IReady && !EOP && !w_empty;
  assign w_cap     = r_state == ST_WR && DACK && IReady && !EOP && !r_tx_valid;
  assign w_push_ok = key_valid && (!w_full || w_pop);
  assign w_cnt_nxt = w_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
  assign w_go      = (!w_empty || !r_tx_valid) && !EOP;
  // IOR wins when both strobes are high; with nothing queued the request is ignored
  assign w_rd_go   = DACK && IOR && !w_empty;
  assign w_wr_go   = DACK && IOW && !IOR && !r_tx_valid;
  assign w_tready  = r_state == ST_RD || (r_state == ST_WR && !r_tx_valid);
  assign TReady    = DACK ? w_tready : 1'bz;
  assign Data_Bus  = (DACK && IOR && r_state == ST_RD) ? w_head : {WIDTH{1'bz}};
  assign DREQ      = r_dreq;
  assign IOflag    = r_ioflag;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign overflow  = r_ovf;
  // DREQ is registered alongside the state it belongs to
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_dreq   <= 1'b0;
      r_ioflag <= 1'b0;
    end else begin
      r_ioflag <= w_cnt_nxt != '0;
      case (r_state)
        ST_IDLE: if (w_go) begin
          r_state <= ST_REQ;
          r_dreq  <= 1'b1;
        end
        ST_REQ: r_state <= w_rd_go ? ST_RD : w_wr_go ? ST_WR : ST_REQ;
        ST_RD: if (!DACK || EOP || w_cnt_nxt == '0) begin
          r_state <= ST_HOLD;
          r_dreq  <= 1'b0;
        end
        ST_WR: if (!DACK || EOP || w_cap) begin
          r_state <= ST_HOLD;
          r_dreq  <= 1'b0;
        end
        ST_HOLD: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_dreq  <= 1'b0;
        end
      endcase
    end
  always_ff @(posedge clk or negedge Reset)
    if (!Reset) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_tx_data  <= Data_Bus;
        r_tx_valid <= 1'b1;
      end else if (tx_ack) r_tx_valid <= 1'b0;
      if (key_valid && w_full && !w_pop) r_ovf <= 1'b1;
    end
endmodule

// File: doc/io_dma_periph.md
IO_DMA_PERIPH -- requirements
Module: io_dma_periph

Interface
REQ-001 Parameter DEPTH, default 8, depth of the receive FIFO (power of two, 2..16).
REQ-002 Parameter WIDTH, default 8, data width; equals Data_Bus width.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 key_valid  input  1  device-side strobe: key_data is pushed into the FIFO on this edge.
REQ-006 key_data  input  WIDTH  device-side byte.
REQ-007 DREQ  output  1  DMA service request to the DMA controller, registered.
REQ-008 DACK  input  1  DMA acknowledge; selects this device on the bus.
REQ-009 IOR  input  1  DMA reading from the device (device-to-memory).
REQ-010 IOW  input  1  DMA writing to the device (memory-to-device).
REQ-011 EOP  input  1  terminal count / end of process from the DMA controller.
REQ-012 IReady  input  1  initiator ready.
REQ-013 TReady  output  1  target ready; tri-stated unless DACK=1.
REQ-014 Data_Bus  inout  WIDTH  shared data bus; driven only when DACK=1, IOR=1 and in state RD.
REQ-015 IOflag  output  1  1 = pending transfer is device-to-memory (FIFO non-empty).
REQ-016 tx_data  output  WIDTH  last byte written by the DMA.
REQ-017 tx_valid  output  1  tx_data holds an unconsumed byte.
REQ-018 tx_ack  input  1  downstream consumer took tx_data.
REQ-019 overflow  output  1  sticky flag: a push was dropped because the FIFO was full.

Function
REQ-020 FSM states: IDLE, REQ, RD, WR, HOLD.
REQ-021 IDLE->REQ when FIFO count>0 or tx_valid=0, and EOP=0; DREQ=1 in REQ, RD and WR only.
REQ-022 REQ->RD when DACK=1 and IOR=1 and count>0; REQ->WR when DACK=1, IOW=1 and tx_valid=0.
REQ-023 RD: drive Data_Bus with FIFO head, TReady=1; pop on each edge with IReady=1 and TReady=1.
REQ-024 WR: TReady=1 while tx_valid=0; on an edge with IReady=1 capture Data_Bus into tx_data and set tx_valid.
REQ-025 RD->HOLD when DACK falls, the FIFO empties, or EOP=1; WR->HOLD when DACK falls, a byte is captured, or EOP=1.
REQ-026 HOLD lasts exactly one cycle with DREQ=0, then goes to IDLE.
REQ-027 Latency: key_valid sampled at edge E1 into an empty FIFO with the FSM in IDLE -> DREQ=1 after edge E2.
REQ-028 A push while full is dropped, FIFO contents are unchanged, and overflow is set.
REQ-029 Simultaneous push and pop: both occur and count is unchanged; push at full with a pop the same edge is accepted.
REQ-030 Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
REQ-031 tx_ack=1 clears tx_valid; a capture and tx_ack on the same edge leaves tx_valid=1.
REQ-032 IOR and IOW both high with DACK=1: treat as RD if count>0, else ignore.
REQ-033 IOflag = (count>0), registered with DREQ.

Reset
REQ-034 Reset=0 immediately forces: state=IDLE, DREQ=0, FIFO empty, tx_valid=0, tx_data=0, overflow=0, TReady and Data_Bus high-Z.
REQ-035 Reset asserted mid-transfer drops the bus at once; no pop or capture occurs on that edge.

Structure
REQ-036 FSM state encoding and the bus-width constant shall live in a shared package, io_dma_pkg.
REQ-037 The FIFO shall be one sub-module, io_fifo (parameterized WIDTH, DEPTH, with full, empty and count outputs).

Verification
REQ-038 Push 0x41, 0x42; DMA raises DACK+IOR with IReady=1 -> bus shows 0x41 then 0x42, then HOLD with DREQ=0 one cycle, then IDLE.
REQ-039 Push 9 bytes with DEPTH=8 -> overflow=1; the 9th byte is absent; reads return the first 8 in order.
REQ-040 DACK+IOW with Data_Bus=0x5A and IReady=1 -> tx_data=0x5A, tx_valid=1; tx_ack -> tx_valid=0.
REQ-041 EOP=1 during RD with 3 bytes queued -> HOLD, DREQ=0 one cycle, then DREQ re-asserts with 3 bytes still queued.
REQ-042 Reset=0 during RD -> Data_Bus=Z the same cycle; FIFO empty after release.
REQ-043 Full FIFO with simultaneous key_valid and pop -> count stays 8, overflow stays 0.
